dffram_dual_port_arbiter: RTL

- Shares one DFFRAM256x16 instance (single port: WE0[1:0], EN0, A0[7:0], Di0[15:0], Do0[15:0]) between two requesters, port 0 and port 1.
- Uses a round-robin grant with optional bounded lock (burst) per port.
- Registers the RAM command, tracks the requester of each in-flight read, and returns read data on the owning port.
- Sits between two bus masters (e.g. CPU data side and a DMA engine) and the RAM macro.

---
 rtl/dffram_dual_port_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dffram_dual_port_arbiter.sv
// Round-robin, lock-capable arbiter sharing one DFFRAM256x16 between two ports.
// Define DFFRAM_ARB_STATS_EN to build the CONFLICT_CNT contention counter.
module dffram_dual_port_arbiter #(
   parameter int MAX_LOCK  = 4,
   parameter bit INIT_PRIO = 1'b0
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic        LOCK0,
   input  logic        LOCK1,
   input  logic [1:0]  WE0_I,
   input  logic [1:0]  WE1_I,
   input  logic [7:0]  A0_I,
   input  logic [7:0]  A1_I,
   input  logic [15:0] DI0_I,
   input  logic [15:0] DI1_I,
   output logic        GNT0,
   output logic        GNT1,
   output logic        RVALID0,
   output logic        RVALID1,
   output logic [15:0] RDATA0,
   output logic [15:0] RDATA1,
   output logic        RAM_EN,
   output logic [1:0]  RAM_WE,
   output logic [7:0]  RAM_A,
   output logic [15:0] RAM_DI,
   input  logic [15:0] RAM_DO,
   output logic [15:0] CONFLICT_CNT
);

   typedef struct packed {
      logic [1:0]  we;
      logic [7:0]  a;
      logic [15:0] di;
   } cmd_t;

   localparam logic [3:0] LOCK_LIM = 4'(MAX_LOCK);

   logic       last_grant;
   logic       lock_on;
   logic [3:0] lock_cnt;

   logic       both;
   logic       any_req;
   logic       hold;
   logic       pick;
   logic       pick_lock;
   cmd_t       cmd;

   logic       s1_tag;
   logic       s2_tag;
   logic       s2_rd;

   always_comb begin
      both    = REQ0 & REQ1;
      any_req = RST_N & (REQ0 | REQ1);
      // owner keeps the slot while its contested re-grants stay under the limit
      hold    = lock_on & (lock_cnt < LOCK_LIM);
      pick    = 1'b0;
      unique case (1'b1)
         both && hold:   pick = last_grant;
         both && !hold:  pick = ~last_grant;
         !both && REQ1:  pick = 1'b1;
         default:        pick = 1'b0;
      endcase
   end

   always_comb begin
      GNT0      = any_req & ~pick;
      GNT1      = any_req & pick;
      pick_lock = pick ? LOCK1 : LOCK0;
      cmd       = pick ? {WE1_I, A1_I, DI1_I}
                       : {WE0_I, A0_I, DI0_I};
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_grant <= ~INIT_PRIO;
         lock_on    <= 1'b0;
         lock_cnt   <= 4'd0;
      end else if (any_req) begin
         last_grant <= pick;
         lock_on    <= pick_lock;
         if ((pick != last_grant) || !pick_lock)
            lock_cnt <= 4'd0;
         else if (both)
            lock_cnt <= lock_cnt + 4'd1;
      end
   end

   // command stage: address and data hold when idle
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         RAM_EN <= 1'b0;
         RAM_WE <= 2'b00;
         RAM_A  <= 8'h00;
         RAM_DI <= 16'h0000;
         s1_tag <= 1'b0;
      end else begin
         RAM_EN <= any_req;
         if (any_req) begin
            RAM_WE <= cmd.we;
            RAM_A  <= cmd.a;
            RAM_DI <= cmd.di;
            s1_tag <= pick;
         end else begin
            RAM_WE <= 2'b00;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s2_rd  <= 1'b0;
         s2_tag <= 1'b0;
      end else begin
         s2_rd  <= RAM_EN & (RAM_WE == 2'b00);
         s2_tag <= s1_tag;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         RVALID0 <= 1'b0;
         RVALID1 <= 1'b0;
         RDATA0  <= 16'h0000;
         RDATA1  <= 16'h0000;
      end else begin
         RVALID0 <= s2_rd & ~s2_tag;
         RVALID1 <= s2_rd & s2_tag;
         if (s2_rd && !s2_tag)
            RDATA0 <= RAM_DO;
         if (s2_rd && s2_tag)
            RDATA1 <= RAM_DO;
      end
   end

`ifdef DFFRAM_ARB_STATS_EN
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         CONFLICT_CNT <= 16'h0000;
      else if (REQ0 && REQ1 && (CONFLICT_CNT != 16'hFFFF))
         CONFLICT_CNT <= CONFLICT_CNT + 16'd1;
   end
`else
   assign CONFLICT_CNT = 16'h0000;
`endif

endmodule
